instr_fetch_unit: RTL and testbench

Fetch sequencer and IF/ID pipeline register sitting directly downstream of the 32x32 instruction memory (A_MemoriaA).
- Walks the program from address 0 by driving the memory index and read strobe.
- Registers each returned word and splits out its R-type fields plus an ALU operation code.
- Hands each entry to the execute stage over a valid/ready handshake, with full backpressure.

---
 rtl/fetch_pkg.sv | 32 +++
 rtl/rtype_decoder.sv | 34 +++
 rtl/instr_fetch_unit.sv | 126 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch stage and the R-type decoder.
// The decoder is reused by the execute stage, so these constants live here.
package fetch_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_FETCH = S_FETCH,
    ST_DRAIN = S_DRAIN,
    ST_DONE  = S_DONE
  } fetch_state_e;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_MUL = 3'd4;
  localparam logic [2:0] ALU_ILL = 3'd7;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_MUL = 6'b011000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;

endpackage

// File: rtl/rtype_decoder.sv
// Combinational R-type decode: register fields plus ALU operation.
// Fields are always extracted; legality only affects alu_op/illegal.
module rtype_decoder
  import fetch_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [2:0]  alu_op,
  output logic        illegal
);

  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign rd = instr[15:11];

  always_comb begin
    alu_op = ALU_ILL;
    if (instr[31:26] == OP_RTYPE) begin
      case (instr[5:0])
        F_ADD:   alu_op = ALU_ADD;
        F_SUB:   alu_op = ALU_SUB;
        F_OR:    alu_op = ALU_OR;
        F_AND:   alu_op = ALU_AND;
        F_MUL:   alu_op = ALU_MUL;
        default: alu_op = ALU_ILL;
      endcase
    end
  end

  assign illegal = (alu_op == ALU_ILL);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer and IF/ID pipeline register in front of the instruction memory.
// state    | meaning
// IDLE     | waiting for start after reset
// FETCH    | reading memory, loading IF/ID whenever it is empty or being accepted
// DRAIN    | last word loaded, waiting for the consumer to take it
// DONE     | run complete, waiting for a new start
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int PROG_LEN = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_index,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [4:0]        id_rs,
  output logic [4:0]        id_rt,
  output logic [4:0]        id_rd,
  output logic [2:0]        id_alu_op,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              load, launch, accept;

  logic [4:0] dec_rs, dec_rt, dec_rd;
  logic [2:0] dec_alu_op;
  logic       dec_illegal;

  rtype_decoder u_dec (
    .instr   (mem_data),
    .rs      (dec_rs),
    .rt      (dec_rt),
    .rd      (dec_rd),
    .alu_op  (dec_alu_op),
    .illegal (dec_illegal)
  );

  assign accept = id_valid && id_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    launch  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          launch  = 1'b1;
          pc_d    = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!id_valid || id_ready) begin
          load = 1'b1;
          // Stop at the last address instead of advancing, so pc never wraps.
          if (pc_q == LAST_PC) state_d = ST_DRAIN;
          else                 pc_d    = pc_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (accept) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid  <= 1'b0;
      id_instr  <= '0;
      id_pc     <= '0;
      id_rs     <= '0;
      id_rt     <= '0;
      id_rd     <= '0;
      id_alu_op <= '0;
      err       <= 1'b0;
    end else begin
      if (load) begin
        // A load coinciding with an accept replaces the entry, keeping valid high.
        id_valid  <= 1'b1;
        id_instr  <= mem_data;
        id_pc     <= pc_q;
        id_rs     <= dec_rs;
        id_rt     <= dec_rt;
        id_rd     <= dec_rd;
        id_alu_op <= dec_alu_op;
      end else if (launch || accept) begin
        id_valid <= 1'b0;
      end

      if (launch)                   err <= 1'b0;
      else if (load && dec_illegal) err <= 1'b1;
    end
  end

  assign mem_index = pc_q;
  assign mem_rd    = (state_q == ST_FETCH);
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed/random bench for instr_fetch_unit against a queue-free reference:
// expected entries are simply the program words in address order, decoded by table.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        start = 1'b0;
  logic [4:0]  mem_index;
  logic        mem_rd;
  logic [31:0] mem_data;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [4:0]  id_pc, id_rs, id_rt, id_rd;
  logic [2:0]  id_alu_op;
  logic        busy, done, err;

  logic        start32 = 1'b0;
  logic [4:0]  mem_index32;
  logic        mem_rd32;
  logic [31:0] mem_data32;
  logic        id_valid32;
  logic        id_ready32 = 1'b0;
  logic [31:0] id_instr32;
  logic [4:0]  id_pc32, id_rs32, id_rt32, id_rd32;
  logic [2:0]  id_alu_op32;
  logic        busy32, done32, err32;

  logic [31:0] mem   [32];
  logic [31:0] mem32 [32];
  logic [5:0]  functs [5] = '{6'b100000, 6'b100010, 6'b100101, 6'b100100, 6'b011000};

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  assign mem_data   = mem[mem_index];
  assign mem_data32 = mem32[mem_index32];

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(5), .DATA_W(32), .PROG_LEN(15)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_index(mem_index), .mem_rd(mem_rd), .mem_data(mem_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .busy(busy), .done(done), .err(err)
  );

  instr_fetch_unit #(.ADDR_W(5), .DATA_W(32), .PROG_LEN(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32),
    .mem_index(mem_index32), .mem_rd(mem_rd32), .mem_data(mem_data32),
    .id_valid(id_valid32), .id_ready(id_ready32), .id_instr(id_instr32), .id_pc(id_pc32),
    .id_rs(id_rs32), .id_rt(id_rt32), .id_rd(id_rd32), .id_alu_op(id_alu_op32),
    .busy(busy32), .done(done32), .err(err32)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_op(input logic [31:0] w);
    if (w[31:26] != 6'd0) return 3'd7;
    case (w[5:0])
      6'h20:   return 3'd0;
      6'h22:   return 3'd1;
      6'h25:   return 3'd2;
      6'h24:   return 3'd3;
      6'h18:   return 3'd4;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [31:0] legal_word();
    logic [31:0] w;
    w = {6'd0, 5'($urandom), 5'($urandom), 5'($urandom), 5'd0, functs[$urandom_range(0, 4)]};
    return w;
  endfunction

  task automatic load_program_a();
    for (int i = 0; i < 32; i++) mem[i] = legal_word();
    mem[0]  = 32'h00221820;
    mem[3]  = 32'h00E64022;
    mem[6]  = 32'h00225825;
    mem[9]  = 32'h00227024;
    mem[12] = 32'h00228818;
  endtask

  // mode 0: ready always high, 1: stall 4 cycles at id_pc=2, 2: random ready,
  // 3: ready high and a stray start while pc=7.
  task automatic run15(input int mode);
    int   idx, cyc, last_acc, hold_cnt;
    logic held, seen_ill, exp_final, stray_done;
    logic [31:0] h_instr;
    logic [4:0]  h_pc, h_idx;
    idx = 0; cyc = 0; last_acc = -1; hold_cnt = 0;
    held = 1'b0; seen_ill = 1'b0; stray_done = 1'b0;
    h_instr = '0; h_pc = '0; h_idx = '0;
    exp_final = 1'b0;
    for (int i = 0; i < 15; i++) if (exp_op(mem[i]) == 3'd7) exp_final = 1'b1;

    @(negedge clk); start = 1'b1; id_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    check("start_index0", mem_index, 0);
    check("start_mem_rd", mem_rd, 1);
    check("start_err_clr", err, 0);
    check("start_valid0", id_valid, 0);

    while (!done && cyc < 300) begin
      start = 1'b0;
      if (held) begin
        check("hold_instr", id_instr, h_instr);
        check("hold_pc", id_pc, h_pc);
        check("hold_index", mem_index, h_idx);
      end
      case (mode)
        1: begin
          if (id_valid && id_pc == 5'd2 && hold_cnt < 4) begin
            id_ready = 1'b0; hold_cnt++;
          end else id_ready = 1'b1;
        end
        2: id_ready = 1'($urandom_range(0, 1));
        default: id_ready = 1'b1;
      endcase
      if (mode == 3 && !stray_done && mem_rd && mem_index == 5'd7) begin
        start = 1'b1; stray_done = 1'b1;
      end
      held = id_valid && !id_ready;
      h_instr = id_instr; h_pc = id_pc; h_idx = mem_index;
      if (id_valid && id_ready) begin
        if (idx < 15) begin
          if (exp_op(mem[idx]) == 3'd7) seen_ill = 1'b1;
          check("acc_pc", id_pc, idx);
          check("acc_instr", id_instr, mem[idx]);
          check("acc_rs", id_rs, mem[idx][25:21]);
          check("acc_rt", id_rt, mem[idx][20:16]);
          check("acc_rd", id_rd, mem[idx][15:11]);
          check("acc_alu_op", id_alu_op, exp_op(mem[idx]));
          check("acc_err", err, seen_ill);
          if (mode != 1 && mode != 2) begin
            if (idx == 0) check("first_latency", cyc, 1);
            else          check("back_to_back", cyc, last_acc + 1);
          end
        end else check("extra_accept", idx, 15);
        last_acc = cyc;
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("run_timeout", done, 1);
    check("accept_count", idx, 15);
    check("done_busy", busy, 0);
    check("done_valid", id_valid, 0);
    check("done_mem_rd", mem_rd, 0);
    check("done_index", mem_index, 14);
    repeat (3) @(negedge clk);
    check("err_sticky", err, exp_final);
    check("done_hold", done, 1);
  endtask

  initial begin
    int cyc, cnt;
    logic seen;

    load_program_a();
    for (int i = 0; i < 32; i++) mem32[i] = legal_word();

    rst = 1'b1;
    #12;
    check("rst_valid", id_valid, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_index", mem_index, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_alu_op", id_alu_op, 0);
    @(negedge clk); rst = 1'b0;

    // Reset mid-FETCH at pc=6.
    @(negedge clk); start = 1'b1; id_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!(mem_rd && mem_index == 5'd6) && cyc < 50) begin
      @(negedge clk); cyc++;
    end
    check("reach_pc6", mem_index, 6);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", id_valid, 0);
    check("midrst_mem_rd", mem_rd, 0);
    check("midrst_index", mem_index, 0);
    check("midrst_busy", busy, 0);
    check("midrst_pc", id_pc, 0);
    @(negedge clk); rst = 1'b0;

    run15(0);
    run15(1);

    mem[5] = 32'hFC000000;
    run15(3);
    load_program_a();
    run15(0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 32; i++)
        mem[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom) : legal_word();
      run15(2);
    end

    // Full-depth program on the 32-entry instance with toggling ready.
    id_ready = 1'b0;
    @(negedge clk); start32 = 1'b1;
    @(negedge clk); start32 = 1'b0;
    cyc = 0; cnt = 0; seen = 1'b0;
    while (!done32 && cyc < 400) begin
      id_ready32 = cyc[0];
      if (id_valid32 && id_ready32) begin
        if (cnt < 32) begin
          check("p32_pc", id_pc32, cnt);
          check("p32_instr", id_instr32, mem32[cnt]);
          if (cnt == 31) check("p32_done_late", done32, 0);
        end
        cnt++;
      end
      if (mem_index32 == 5'd0 && cnt > 1) seen = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check("p32_timeout", done32, 1);
    check("p32_count", cnt, 32);
    check("p32_no_wrap", seen, 0);
    check("p32_index", mem_index32, 31);
    check("p32_err", err32, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
